// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall detection.
// Control outputs are cleared whenever a bubble is captured, so they are already gated by ex_valid.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic              id_use_imm,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              mem_reg_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store,
    output logic [REG_AW-1:0] ex_rd,
    output logic [ALUC_W-1:0] ex_aluc,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr
);

    logic              bubble;
    logic [DATA_W-1:0] rs_cap;
    logic [DATA_W-1:0] rt_cap;
    logic [DATA_W-1:0] rs_val_q;
    logic [DATA_W-1:0] rt_val_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_idx_q;
    logic [REG_AW-1:0] rt_idx_q;
    logic              use_imm_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    always_comb begin
        stall = 1'b0;
        if (!rst && id_valid && ex_valid && ex_mem_rd && (ex_rd != '0))
            stall = (ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt));
    end

    // The register file is written at the end of WB, so the ID read misses that value.
    always_comb begin
        bubble = flush || stall || !id_valid;
        rs_cap = id_rs_val;
        rt_cap = id_rt_val;
        if (wb_reg_we && (wb_rd != '0) && (wb_rd == id_rs))
            rs_cap = wb_result;
        if (wb_reg_we && (wb_rd != '0) && (wb_rd == id_rt))
            rt_cap = wb_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_reg_we <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_pc     <= '0;
            ex_rd     <= '0;
            ex_aluc   <= '0;
            rs_val_q  <= '0;
            rt_val_q  <= '0;
            imm_q     <= '0;
            rs_idx_q  <= '0;
            rt_idx_q  <= '0;
            use_imm_q <= 1'b0;
        end else begin
            ex_valid  <= !bubble;
            ex_reg_we <= !bubble && id_reg_we;
            ex_mem_rd <= !bubble && id_mem_rd;
            ex_mem_wr <= !bubble && id_mem_wr;
            ex_pc     <= id_pc;
            ex_rd     <= id_rd;
            ex_aluc   <= id_aluc;
            rs_val_q  <= rs_cap;
            rt_val_q  <= rt_cap;
            imm_q     <= id_imm;
            rs_idx_q  <= id_rs;
            rt_idx_q  <= id_rt;
            use_imm_q <= id_use_imm;
        end
    end

    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        fwd_rs = rs_val_q;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs_idx_q))
            fwd_rs = mem_result;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rs_idx_q))
            fwd_rs = wb_result;

        fwd_rt = rt_val_q;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == rt_idx_q))
            fwd_rt = mem_result;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rt_idx_q))
            fwd_rt = wb_result;
    end

    always_comb begin
        ex_a     = fwd_rs;
        ex_b     = use_imm_q ? imm_q : fwd_rt;
        ex_store = fwd_rt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_id_ex_stage;

    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt, id_use_imm;
    logic [3:0]  id_aluc;
    logic        id_reg_we, id_mem_rd, id_mem_wr;
    logic        mem_reg_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_aluc;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        full;
        logic        valid;
        logic        stall;
        logic [31:0] pc, a, b, st;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic        we, mrd, mwr;
    } exp_t;

    exp_t sb[$];

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUC_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_use_imm(id_use_imm), .id_aluc(id_aluc), .id_reg_we(id_reg_we),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .mem_reg_we(mem_reg_we),
        .mem_rd(mem_rd), .mem_result(mem_result), .wb_reg_we(wb_reg_we),
        .wb_rd(wb_rd), .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_store(ex_store), .ex_rd(ex_rd),
        .ex_aluc(ex_aluc), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".ex_valid"},  32'(ex_valid),  32'(e.valid));
            chk({e.name, ".stall"},     32'(stall),     32'(e.stall));
            chk({e.name, ".ex_reg_we"}, 32'(ex_reg_we), 32'(e.we));
            chk({e.name, ".ex_mem_rd"}, 32'(ex_mem_rd), 32'(e.mrd));
            chk({e.name, ".ex_mem_wr"}, 32'(ex_mem_wr), 32'(e.mwr));
            if (e.full) begin
                chk({e.name, ".ex_pc"},    ex_pc,          e.pc);
                chk({e.name, ".ex_a"},     ex_a,           e.a);
                chk({e.name, ".ex_b"},     ex_b,           e.b);
                chk({e.name, ".ex_store"}, ex_store,       e.st);
                chk({e.name, ".ex_rd"},    32'(ex_rd),     32'(e.rd));
                chk({e.name, ".ex_aluc"},  32'(ex_aluc),   32'(e.aluc));
            end
        end
    end

    task automatic push_instr(input string n, input logic [31:0] pc, a, b, st,
                              input logic [4:0] rd, input logic [3:0] aluc,
                              input logic we, mrd, mwr, stall_e, valid_e = 1'b1);
        exp_t e;
        e.name = n; e.full = 1'b1; e.valid = valid_e; e.stall = stall_e;
        e.pc = pc; e.a = a; e.b = b; e.st = st; e.rd = rd; e.aluc = aluc;
        e.we = we; e.mrd = mrd; e.mwr = mwr;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string n, input logic stall_e);
        exp_t e;
        e.name = n; e.full = 1'b0; e.valid = 1'b0; e.stall = stall_e;
        e.pc = '0; e.a = '0; e.b = '0; e.st = '0; e.rd = '0; e.aluc = '0;
        e.we = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_reset(input string n);
        push_instr(n, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                          input logic [31:0] rsv, rtv, imm, input logic uses_rt, use_imm,
                          input logic [3:0] aluc, input logic we, mrd, mwr);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
        id_uses_rt = uses_rt; id_use_imm = use_imm; id_aluc = aluc;
        id_reg_we = we; id_mem_rd = mrd; id_mem_wr = mwr;
    endtask

    task automatic fwd_set(input logic mwe, input logic [4:0] mrd_i, input logic [31:0] mres,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_we = mwe; mem_rd = mrd_i; mem_result = mres;
        wb_reg_we = wwe; wb_rd = wrd; wb_result = wres;
    endtask

    task automatic rand_inputs();
        flush = 1'($urandom);
        id_set(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
        fwd_set(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: scoreboard still holds %0d entries", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_set(0, '0, '0, '0, '0, '0, '0, '0, 0, 0, '0, 0, 0, 0);
        fwd_set(0, '0, '0, 0, '0, '0);

        // Reset with random inputs
        step(); rand_inputs(); push_reset("t1_rst_a");
        step(); rand_inputs(); push_reset("t1_rst_b");

        step(); rst = 1'b0; flush = 1'b0;
        id_set(1, 32'h100, 3, 2, 4, 32'h11, 32'h22, 0, 1, 0, ALU_SLT, 1, 0, 0);
        fwd_set(0, 0, 0, 0, 0, 0);
        push_bubble("c1_idle", 0);

        step();
        id_set(1, 32'h104, 3, 1, 7, 32'h33, 32'h44, 0, 1, 0, ALU_SUB, 1, 0, 0);
        fwd_set(1, 3, 32'd5, 0, 0, 0);
        push_instr("t2_mem_fwd", 32'h100, 32'd5, 32'h22, 32'h22, 4, ALU_SLT, 1, 0, 0, 0);

        step();
        id_set(1, 32'h108, 3, 1, 8, 32'h55, 32'h66, 0, 1, 0, ALU_ADD, 1, 0, 0);
        fwd_set(1, 3, 32'd7, 1, 3, 32'd9);
        push_instr("t3_mem_over_wb", 32'h104, 32'd7, 32'h44, 32'h44, 7, ALU_SUB, 1, 0, 0, 0);

        step();
        id_set(1, 32'h10C, 1, 5, 5, 32'h1000, 32'h0, 32'h10, 0, 1, ALU_ADD, 1, 1, 0);
        fwd_set(0, 3, 32'd7, 1, 3, 32'd9);
        push_instr("t3_wb_fwd", 32'h108, 32'd9, 32'h66, 32'h66, 8, ALU_ADD, 1, 0, 0, 0);

        // Load-use: LW $5 in EX, ADD $6,$5,$1 in ID
        step();
        id_set(1, 32'h110, 5, 1, 6, 32'hDEAD, 32'h1000, 0, 1, 0, ALU_ADD, 1, 0, 0);
        fwd_set(0, 0, 0, 0, 0, 0);
        push_instr("t4_load_stall", 32'h10C, 32'h1000, 32'h10, 32'h0, 5, ALU_ADD, 1, 1, 0, 1);

        step();
        fwd_set(1, 5, 32'h1010, 0, 0, 0);
        push_bubble("t4_bubble", 0);

        step();
        id_valid = 1'b0;
        fwd_set(0, 5, 32'h1010, 1, 5, 32'hCAFE);
        push_instr("t4_load_fwd", 32'h110, 32'hCAFE, 32'h1000, 32'h1000, 6, ALU_ADD, 1, 0, 0, 0);

        // $0 is never bypassed nor forwarded
        step();
        id_set(1, 32'h118, 0, 0, 10, 32'h0, 32'h0, 0, 1, 0, ALU_OR, 1, 0, 0);
        fwd_set(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
        push_bubble("c8_bubble", 0);

        step();
        id_set(1, 32'h11C, 1, 11, 11, 32'h2000, 32'h0, 32'd4, 0, 1, ALU_ADD, 1, 1, 0);
        fwd_set(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
        push_instr("t5_zero_reg", 32'h118, 32'h0, 32'h0, 32'h0, 10, ALU_OR, 1, 0, 0, 0);

        // Stall through the rt path, squashed by a simultaneous flush
        step();
        id_set(1, 32'h120, 2, 11, 12, 32'h22, 32'h99, 0, 1, 0, ALU_SUB, 1, 0, 0);
        flush = 1'b1;
        fwd_set(0, 0, 0, 0, 0, 0);
        push_instr("t5_stall_rt", 32'h11C, 32'h2000, 32'd4, 32'h0, 11, ALU_ADD, 1, 1, 0, 1);

        step();
        flush = 1'b0;
        id_valid = 1'b0;
        push_bubble("t5_flush", 0);

        step();
        id_set(1, 32'h130, 1, 13, 13, 32'h3000, 32'h0, 32'd8, 0, 1, ALU_ADD, 1, 1, 0);
        push_bubble("c12_bubble", 0);

        // rt field matches the load destination but is not read
        step();
        id_set(1, 32'h134, 2, 13, 15, 32'h22, 32'h0, 32'd1, 0, 1, ALU_ADD, 1, 0, 0);
        push_instr("t4_rt_unused", 32'h130, 32'h3000, 32'd8, 32'h0, 13, ALU_ADD, 1, 1, 0, 0);

        step();
        id_set(1, 32'h138, 1, 13, 13, 32'h4000, 32'h0, 32'd8, 0, 1, ALU_ADD, 1, 1, 0);
        push_instr("c14_addi", 32'h134, 32'h22, 32'd1, 32'h0, 15, ALU_ADD, 1, 0, 0, 0);

        step();
        id_set(1, 32'h13C, 13, 2, 14, 32'h0, 32'h22, 0, 1, 0, ALU_ADD, 1, 0, 0);
        push_instr("c15_stall", 32'h138, 32'h4000, 32'd8, 32'h0, 13, ALU_ADD, 1, 1, 0, 1);

        // Reset asserted between edges while the stall is active
        @(negedge clk);
        #1 rst = 1'b1;
        step();
        push_reset("t_rst_mid_stall");

        step();
        rst = 1'b0;
        id_set(1, 32'h200, 1, 15, 0, 32'h500, 32'h77, 32'hFFFF_FFF0, 1, 1, ALU_ADD, 0, 0, 1);
        push_bubble("c17_after_rst", 0);

        step();
        id_set(1, 32'h204, 17, 18, 16, 32'h1, 32'h2, 0, 1, 0, ALU_XOR, 1, 0, 0);
        fwd_set(1, 15, 32'd3, 1, 18, 32'hABCD);
        push_instr("t6_imm", 32'h200, 32'h500, 32'hFFFF_FFF0, 32'd3, 0, ALU_ADD, 0, 0, 1, 0);

        step();
        id_valid = 1'b0;
        fwd_set(0, 0, 0, 0, 0, 0);
        push_instr("t_wb_capture", 32'h204, 32'h1, 32'hABCD, 32'hABCD, 16, ALU_XOR, 1, 0, 0, 0);

        step();
        push_bubble("drain", 0);

        step();
        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
